fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage of the 2-stack processor.
- Holds the 16-bit PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each fetched word in an instruction register to the decoder over a valid/ready handshake.
- Exports PC[15:13] to the 3b/13b merger and takes the merged 16-bit jump target back as the redirect address.

Parameters:
RESET_PC  16'h0000  PC value loaded on reset
TIMEOUT   15        fetch-wait cycles before a retry; legal range 1..2^CNT_W-1
CNT_W     4         width of the wait counter

Ports:
clk          input   1   system clock; all state updates on rising edge
rst_n        input   1   asynchronous active-low reset
mem_addr     output  16  instruction memory address; equals pc
mem_req      output  1   fetch request; high only in FETCH
mem_ack      input   1   memory ack; mem_rdata valid in the same cycle
mem_rdata    input   16  instruction word from memory
ir           output  16  instruction register
ir_valid     output  1   ir holds an unconsumed instruction
ir_ready     input   1   decoder accepts ir this cycle
jump         input   1   redirect request, qualified by ir_valid & ir_ready
jump_target  input   16  merged target {pc_hi, imm13} from the merger
pc_hi        output  3   pc[15:13], to the merger a input
fetch_retry  output  1   one-cycle pulse when a fetch timed out

Behaviour:
- Reset, asynchronous while rst_n=0:
  - pc=RESET_PC, ir=16'h0000, ir_valid=0, fetch_retry=0, wait counter=0, state=IDLE.
  - mem_req=0 and mem_addr=RESET_PC throughout reset.
- States: IDLE, FETCH, HOLD, RETRY. mem_req=(state==FETCH). mem_addr=pc and pc_hi=pc[15:13] continuously.
- IDLE:
  - Unconditionally goes to FETCH next cycle.
  - The first mem_req is therefore the 2nd rising edge after rst_n rises.
- FETCH:
  - mem_ack=1: ir<=mem_rdata, ir_valid<=1, pc<=pc+1 (16-bit, 16'hFFFF wraps to 16'h0000), counter<=0, go to HOLD.
  - An ack in the first FETCH cycle is legal, giving 1-cycle fetch latency.
  - mem_ack=0 and counter==TIMEOUT-1: fetch_retry<=1 for one cycle, counter<=0, go to RETRY.
  - Otherwise counter<=counter+1.
- RETRY:
  - mem_req=0 for exactly one cycle, pc unchanged, then back to FETCH at the same address.
  - A mem_ack arriving in RETRY is ignored.
- HOLD:
  - ir_valid=1 and ir stable.
  - ir_ready=1: ir_valid<=0, go to FETCH.
  - If jump=1 in that same cycle, pc<=jump_target; otherwise pc keeps its post-increment value.
- Handshake timing:
  - Back-to-back throughput is one instruction per 2 cycles minimum: ack cycle, then the ready cycle.
  - There is no overlap of fetch and hold.
- Ignored inputs:
  - jump outside an accepted HOLD cycle has no effect.
  - ir_ready outside HOLD has no effect.
- Merger timing: pc_hi is the already-incremented pc during HOLD. The merger output therefore targets the page of the next sequential instruction; this matches the ISA definition.
- Reset mid-fetch or mid-hold: everything returns to reset values immediately, and any pending instruction is discarded.
- No X propagation: ir is written only on an accepted ack.

Test Plan:
1. Reset release, mem_ack tied high, mem_rdata=16'hE007 -> mem_req rises the 2nd edge after rst_n; ir=16'hE007, ir_valid=1 one cycle later; pc=16'h0001, mem_addr=16'h0001.
2. Sequential stream, ir_ready=1, mem_ack after 3 wait cycles per fetch -> ir_valid pulses every 5 cycles; pc steps 0,1,2,3; no fetch_retry.
3. Jump: in HOLD with pc=16'hC124 (pc_hi=3'b110), drive jump=1, jump_target=16'hC924, ir_ready=1 -> next mem_addr=16'hC924; with jump=0 instead, mem_addr=16'hC124.
4. Timeout: mem_ack held low 15 cycles -> fetch_retry pulses once, mem_req low 1 cycle, then re-requests the same address. An ack arriving in the RETRY cycle is dropped.
5. Wrap: pc=16'hFFFF, fetch acked -> pc=16'h0000, pc_hi=3'b000.
6. Backpressure then reset: HOLD with ir_ready=0 for 10 cycles -> ir stable, mem_req=0. Assert rst_n=0 mid-hold -> ir_valid=0, ir=0, pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage of the 2-stack processor.
// Fetches one word per req/ack transaction and holds it in ir until the decoder accepts it.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15,
  parameter int          CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        jump,
  input  logic [15:0] jump_target,
  output logic [2:0]  pc_hi,
  output logic        fetch_retry
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    RETRY = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [15:0]      pc_q;
  logic [15:0]      ir_q;
  logic             ir_valid_q;
  logic             retry_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every register below is written with <= so all of them see the
  // pre-edge values of each other; a blocking = here would chain updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      retry_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      retry_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            ir_q       <= mem_rdata;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + 16'd1;
            cnt_q      <= '0;
            state_q    <= HOLD;
          end else if (cnt_q == CNT_LAST) begin
            retry_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= RETRY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          // Jumps only take effect on the cycle the decoder consumes ir.
          if (ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= FETCH;
            if (jump) begin
              pc_q <= jump_target;
            end
          end
        end
        RETRY: begin
          state_q <= FETCH;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = pc_q;
  assign mem_req     = (state_q == FETCH);
  assign pc_hi       = pc_q[15:13];
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_retry = retry_q;

endmodule
